// File: rtl/code_ram_arbiter.sv
// Code SRAM arbiter: instruction fetch vs data bus in RUN, with an exclusive UART codeload session (LOAD/RELEASE).
// Define KMIE_CODE_ARB_RR_EN for if/dm round-robin; otherwise dm has fixed priority over if.
module code_ram_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_be,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  ld_mode,
  input  logic                  ld_req,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_W-1:0]     ld_wdata,
  output logic                  ld_gnt,
  output logic [ADDR_W:0]       ld_count,
  output logic                  boot_done,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_e;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            if_rv_q, dm_rv_q;

`ifdef KMIE_CODE_ARB_RR_EN
  // rr_q=1 means fetch wins the next contended cycle; reset favours dm.
  logic rr_q, rr_d;

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    boot_done = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
`ifdef KMIE_CODE_ARB_RR_EN
    rr_d      = rr_q;
`endif
    if (rst) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (ld_mode) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
`ifdef KMIE_CODE_ARB_RR_EN
            if (dm_req && (!if_req || !rr_q)) dm_gnt = 1'b1;
            else if (if_req)                  if_gnt = 1'b1;
            if (dm_gnt)      rr_d = 1'b1;
            else if (if_gnt) rr_d = 1'b0;
`else
            dm_gnt = dm_req;
            if_gnt = if_req && !dm_req;
`endif
            if (dm_gnt) begin
              mem_we    = dm_we;
              mem_addr  = dm_addr;
              mem_wdata = dm_wdata;
              mem_be    = dm_be;
            end else if (if_gnt) begin
              mem_addr  = if_addr;
            end
          end
        end
        LOAD: begin
          if (!ld_mode) begin
            state_d = RELEASE;
          end else begin
            ld_gnt    = ld_req;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            if (ld_req && cnt_q != CNT_MAX) cnt_d = cnt_q + (ADDR_W+1)'(1);
          end
        end
        RELEASE: begin
          boot_done = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    mem_cs = if_gnt | dm_gnt | ld_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      if_rv_q <= 1'b0;
      dm_rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if_rv_q <= if_gnt;
      dm_rv_q <= dm_gnt & ~dm_we;
    end
  end

  assign if_rvalid = if_rv_q;
  assign dm_rvalid = dm_rv_q;
  assign rdata     = mem_rdata;
  assign ld_count  = cnt_q;

endmodule

// File: tb/tb_code_ram_arbiter.sv
// Scoreboard bench for code_ram_arbiter: stimulus queues expected grants/reads, a negedge monitor pops and checks.
module tb_code_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [11:0] if_addr;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] rdata;
  logic        ld_mode, ld_req, ld_gnt, boot_done;
  logic [11:0] ld_addr;
  logic [31:0] ld_wdata;
  logic [12:0] ld_count;
  logic        mem_cs, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  gnt;   // {ld, dm, if}
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gexp_t;

  typedef struct {
    logic [1:0]  port;  // {dm, if}
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  code_ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .rdata(rdata),
    .ld_mode(ld_mode), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_count(ld_count), .boot_done(boot_done),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [11:0] a);
    return 32'hC0DE_0000 ^ {20'h0, a};
  endfunction

  // Synchronous SRAM model: read data appears the cycle after a read select.
  always @(posedge clk) begin
    if (mem_cs && !mem_we) mem_rdata <= memval(mem_addr);
  end

  task automatic exp_g(input logic [2:0] g, input logic we, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    gexp_t e;
    e.gnt = g; e.we = we; e.addr = a; e.wdata = d; e.be = be;
    gq.push_back(e);
  endtask

  task automatic exp_r(input logic [1:0] p, input logic [11:0] a);
    rexp_t e;
    e.port = p; e.data = memval(a);
    rq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any grant or rvalid must match the head of its queue.
  always @(negedge clk) begin
    if (mem_cs || if_gnt || dm_gnt || ld_gnt) begin
      total++;
      if (gq.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got gnt=%b cs=%b addr=%h expected no grant",
                 {ld_gnt, dm_gnt, if_gnt}, mem_cs, mem_addr);
      end else begin
        gexp_t e;
        e = gq.pop_front();
        if ({ld_gnt, dm_gnt, if_gnt} !== e.gnt || mem_cs !== 1'b1 || mem_we !== e.we ||
            mem_addr !== e.addr || (e.we && (mem_wdata !== e.wdata || mem_be !== e.be))) begin
          bad++;
          $display("FAIL grant: got gnt=%b cs=%b we=%b addr=%h wd=%h be=%h expected gnt=%b we=%b addr=%h wd=%h be=%h",
                   {ld_gnt, dm_gnt, if_gnt}, mem_cs, mem_we, mem_addr, mem_wdata, mem_be,
                   e.gnt, e.we, e.addr, e.wdata, e.be);
        end
      end
    end
    if (if_rvalid || dm_rvalid) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: got rv=%b rdata=%h expected none", {dm_rvalid, if_rvalid}, rdata);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        if ({dm_rvalid, if_rvalid} !== r.port || rdata !== r.data) begin
          bad++;
          $display("FAIL rvalid: got rv=%b rdata=%h expected rv=%b rdata=%h",
                   {dm_rvalid, if_rvalid}, rdata, r.port, r.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 12'h001; dm_req = 1'b1; dm_we = 1'b0;
    dm_addr = 12'h002; dm_wdata = '0; dm_be = 4'hF;
    ld_mode = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    #1;
    repeat (3) cyc();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    #2;
    chk("reset_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("reset_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("reset_boot_done", 32'(boot_done), 32'd0);
    chk("reset_ld_count", 32'(ld_count), 32'd0);
    cyc();

    // Single fetch
    if_req = 1'b1; if_addr = 12'h010;
    exp_g(3'b001, 1'b0, 12'h010, '0, '0); exp_r(2'b01, 12'h010);
    cyc();
    if_req = 1'b0;
    cyc(); cyc();

    // Contention for 6 cycles
    if_req = 1'b1; if_addr = 12'h020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h030; dm_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
`ifdef KMIE_CODE_ARB_RR_EN
      if (k % 2 == 0) begin
        exp_g(3'b010, 1'b0, 12'h030, '0, '0); exp_r(2'b10, 12'h030);
      end else begin
        exp_g(3'b001, 1'b0, 12'h020, '0, '0); exp_r(2'b01, 12'h020);
      end
`else
      exp_g(3'b010, 1'b0, 12'h030, '0, '0); exp_r(2'b10, 12'h030);
`endif
      cyc();
    end
    if_req = 1'b0; dm_req = 1'b0;
    cyc(); cyc();

    // Data write: no read-valid follows
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h3FF; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    exp_g(3'b010, 1'b1, 12'h3FF, 32'hDEADBEEF, 4'b0011);
    cyc();
    dm_req = 1'b0; dm_we = 1'b0;
    #2;
    chk("dm_write_no_rvalid", 32'(dm_rvalid), 32'd0);
    cyc();

    // Enter codeload: the entry cycle grants nothing
    ld_mode = 1'b1; if_req = 1'b1; if_addr = 12'h040;
    #2;
    chk("load_entry_if_gnt", 32'(if_gnt), 32'd0);
    cyc();
    dm_req = 1'b1; dm_addr = 12'h050;
    for (int i = 0; i < 5; i++) begin
      ld_req = 1'b1; ld_addr = 12'(i); ld_wdata = 32'h1000 + 32'(i);
      exp_g(3'b100, 1'b1, 12'(i), 32'h1000 + 32'(i), 4'hF);
      cyc();
    end
    ld_req = 1'b0; dm_req = 1'b0;
    #2;
    chk("ld_count_5", 32'(ld_count), 32'd5);
    cyc();

    // Session end: LOAD exit, RELEASE, then fetch resumes
    ld_mode = 1'b0; ld_req = 1'b1; ld_addr = 12'h0AA;
    #2;
    chk("load_exit_boot_done", 32'(boot_done), 32'd0);
    cyc();
    ld_req = 1'b0;
    #2;
    chk("release_boot_done", 32'(boot_done), 32'd1);
    cyc();
    exp_g(3'b001, 1'b0, 12'h040, '0, '0); exp_r(2'b01, 12'h040);
    #2;
    chk("run_boot_done_low", 32'(boot_done), 32'd0);
    chk("run_ld_count_hold", 32'(ld_count), 32'd5);
    cyc();
    if_req = 1'b0;
    cyc(); cyc();

    // Saturation at 2**ADDR_W
    ld_mode = 1'b1;
    cyc();
    #2;
    chk("load_count_cleared", 32'(ld_count), 32'd0);
    for (int i = 0; i < 4097; i++) begin
      ld_req = 1'b1; ld_addr = 12'(i); ld_wdata = 32'(i);
      exp_g(3'b100, 1'b1, 12'(i), 32'(i), 4'hF);
      cyc();
    end
    ld_req = 1'b0;
    #2;
    chk("ld_count_sat", 32'(ld_count), 32'd4096);
    cyc();

    // Reset mid-LOAD: back to RUN, no boot_done
    rst = 1'b1;
    cyc();
    rst = 1'b0; ld_mode = 1'b0;
    #2;
    chk("rst_load_boot_done", 32'(boot_done), 32'd0);
    chk("rst_load_count", 32'(ld_count), 32'd0);
    cyc();
    #2;
    chk("rst_load_boot_done_next", 32'(boot_done), 32'd0);
    cyc();

    // Post-reset contention: dm wins first in either build
    if_req = 1'b1; if_addr = 12'h060; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h070;
    exp_g(3'b010, 1'b0, 12'h070, '0, '0); exp_r(2'b10, 12'h070);
    cyc();
    if_req = 1'b0; dm_req = 1'b0;
    cyc(); cyc();

    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_ram_arbiter.md
CODE_RAM_ARBITER -- requirements
Module: code_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word address width (4096-word code SRAM).
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 clk  in  1  the single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 if_req / if_addr  in  1 / ADDR_W  instruction fetch read request and address.
REQ-006 if_gnt / if_rvalid  out  1 / 1  fetch grant; fetch read-data valid.
REQ-007 dm_req / dm_we / dm_addr / dm_wdata / dm_be  in  1 / 1 / ADDR_W / DATA_W / DATA_W/8  data-bus access.
REQ-008 dm_gnt / dm_rvalid  out  1 / 1  data grant; data read-data valid.
REQ-009 rdata  out  DATA_W  shared read data, qualified by if_rvalid or dm_rvalid.
REQ-010 ld_mode  in  1  codeload session active (UART loader owns the RAM).
REQ-011 ld_req / ld_addr / ld_wdata  in  1 / ADDR_W / DATA_W  loader full-word write.
REQ-012 ld_gnt  out  1  loader write grant.
REQ-013 ld_count  out  ADDR_W+1  loader words written this session.
REQ-014 boot_done  out  1  one-cycle pulse when a codeload session ends.
REQ-015 mem_cs / mem_we / mem_addr / mem_wdata / mem_be  out  1 / 1 / ADDR_W / DATA_W / DATA_W/8  SRAM port.
REQ-016 mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read with mem_cs=1.

Function
REQ-017 FSM states RUN, LOAD, RELEASE; at most one grant per cycle.
REQ-018 Grants are combinational, same cycle as req; granted access drives mem_* that cycle; mem_cs = OR of grants.
REQ-019 Requester holds req/addr/data until gnt; ungranted requests are neither lost nor reordered.
REQ-020 RUN: arbitrate if vs dm; ld_req ignored (ld_gnt=0).
REQ-021 RUN with ld_mode=1: no grants that cycle; next state LOAD.
REQ-022 LOAD: only loader granted; ld_gnt=ld_req; mem_we=1, mem_be all ones; if_gnt=dm_gnt=0.
REQ-023 LOAD with ld_mode=0: next state RELEASE; no grants; a ld_req that cycle is not granted.
REQ-024 RELEASE: no grants for one cycle, boot_done=1, next state RUN.
REQ-025 ld_count cleared on RUN->LOAD, +1 per ld_gnt, saturates at 2**ADDR_W, holds value in RUN.
REQ-026 if_rvalid / dm_rvalid registered: high exactly one cycle after that port's read grant; rdata = mem_rdata pass-through.
REQ-027 Data writes (dm_we=1) produce no dm_rvalid; fetch is read-only (mem_we=0, mem_be ignored).
REQ-028 Read latency grant->rvalid is exactly 1 cycle; back-to-back grants give back-to-back rvalids.

Reset
REQ-029 While rst=1: all grants 0, mem_cs=0; next state RUN.
REQ-030 After reset: rvalids 0, boot_done 0, ld_count 0, round-robin pointer selects dm as first winner.
REQ-031 Reset mid-LOAD or mid-read: session/rvalid discarded, no boot_done pulse.

Configuration
REQ-032 Macro KMIE_CODE_ARB_RR_EN defined: if/dm round-robin; pointer toggles to other port after each grant; each port granted at least every second cycle under contention.
REQ-033 Macro undefined: fixed priority, dm over if; fetch may starve while dm_req held.

Verification
REQ-034 Reset, if_req=1 addr 0x010 -> if_gnt same cycle, mem_addr=0x010, if_rvalid next cycle with rdata=mem_rdata.
REQ-035 if_req and dm_req held 6 cycles -> RR_EN: grants dm,if,dm,if,dm,if; no RR_EN: dm x6, if_gnt=0.
REQ-036 ld_mode=1 in RUN with if_req=1 -> zero grants that cycle, LOAD next; 5 ld_req writes -> ld_count=5, mem_be=4'hF.
REQ-037 ld_mode 1->0 -> one grant-free RELEASE cycle, boot_done pulse 1 cycle, if_gnt resumes following cycle, ld_count stays 5.
REQ-038 4097 loader writes -> ld_count saturates at 4096; rst=1 mid-LOAD -> RUN, ld_count=0, no boot_done.
REQ-039 dm write 0xDEADBEEF be=4'b0011 addr 0x3FF -> mem_we=1, mem_be=4'b0011, no dm_rvalid.
